// File: rtl/async_mem_arb_ctrl.sv
// Two-port round-robin arbiter and access sequencer for an asynchronous SRAM/flash bus.
// Each granted access runs SETUP -> STROBE (wait-extendable) -> HOLD, then returns to IDLE.
module async_mem_arb_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [3:0]    be_n0,
    input  logic [3:0]    be_n1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_dout,
    output logic          mem_doe,
    input  logic [31:0]   mem_din,
    output logic          mem_ce_n,
    output logic          mem_oe_n,
    output logic          mem_we_n,
    output logic [3:0]    mem_be_n,
    input  logic          mem_wait_n
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0] state;
    logic [3:0] cnt;
    logic       gnt;      // granted port
    logic       we_r;
    logic       rr;       // 1 = port 1 preferred on a tie
    logic       pick1;
    logic       last_hold;

    always_comb begin
        pick1 = req1 && (!req0 || rr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt      <= 1'b0;
            we_r     <= 1'b0;
            rr       <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
            mem_be_n <= '1;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= pick1;
                        rr       <= !pick1;
                        we_r     <= pick1 ? we1    : we0;
                        mem_addr <= pick1 ? addr1  : addr0;
                        mem_dout <= pick1 ? wdata1 : wdata0;
                        mem_be_n <= pick1 ? be_n1  : be_n0;
                        cnt      <= 4'(SETUP_CYC);
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'(STROBE_CYC);
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    // Counter parks at 1 while the device stretches the final strobe cycle.
                    if (cnt == 4'd1) begin
                        if (mem_wait_n) begin
                            if (!we_r) begin
                                rdata <= mem_din;
                            end
                            cnt   <= 4'(HOLD_CYC);
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pin strobes decode straight from state so async reset releases them at once.
    assign busy      = (state != IDLE);
    assign mem_ce_n  = !busy;
    assign mem_oe_n  = !((state == STROBE) && !we_r);
    assign mem_we_n  = !((state == STROBE) && we_r);
    assign mem_doe   = busy && we_r;
    assign last_hold = (state == HOLD) && (cnt == 4'd1);
    assign ack0      = last_hold && !gnt;
    assign ack1      = last_hold && gnt;

endmodule

// File: doc/async_mem_arb_ctrl.md
Name: async_mem_arb_ctrl

Overview:
- Shares one asynchronous SRAM/flash-style bus between two synchronous requesters: port 0 (CPU) and port 1 (DMA).
- Arbitrates round-robin and sequences each access through programmable setup, strobe and hold phases.
- Extends the strobe phase while the device holds wait asserted.
- Sits between the system bus fabric and the external async memory pins; that bus is what the async_mem bus model drives and checks in the system bench.

Parameters:
- SETUP_CYC, 1: address/CE setup cycles before the strobe; legal range 1..15.
- STROBE_CYC, 2: minimum cycles OE_n/WE_n is asserted; legal range 1..15.
- HOLD_CYC, 1: cycles address/data are held after the strobe; legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request, held stable until ack.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  AW  byte address.
- wdata0, wdata1  in  32  write data.
- be_n0, be_n1  in  4  active-low byte enables.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  32  read data register, shared by both ports.
- busy  out  1  high in any non-IDLE state.
- mem_addr  out  AW  address to the device.
- mem_dout  out  32  data driven to the device.
- mem_doe  out  1  data output enable, for the tristate at top level.
- mem_din  in  32  data from the device.
- mem_ce_n, mem_oe_n, mem_we_n  out  1  active-low chip enable, output enable, write enable.
- mem_be_n  out  4  active-low byte enables.
- mem_wait_n  in  1  active-low wait; already synchronous to clk.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - Outputs: mem_ce_n/oe_n/we_n = 1, mem_be_n = 4'hF, mem_doe = 0, mem_addr = 0, mem_dout = 0, rdata = 0, ack0/ack1 = 0, busy = 0.
  - State: FSM = IDLE, round-robin pointer = port 0 preferred.
  - An interrupted transaction is never acked. The requester must reissue it.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: sample req0/req1.
  - One request active: grant it.
  - Both active: grant the port the pointer prefers, then point the pointer at the other port.
  - A single grant also points the pointer away from the granted port.
  - On grant, register the winner's addr, wdata, be_n and we into mem_addr/mem_dout/mem_be_n. Load the phase counter with SETUP_CYC and go to SETUP.
- SETUP: mem_ce_n = 0, strobes deasserted. mem_doe = 1 on writes.
  - Go to STROBE after SETUP_CYC cycles.
- STROBE: mem_oe_n = 0 (read) or mem_we_n = 0 (write).
  - Run at least STROBE_CYC cycles.
  - If mem_wait_n = 0 in the final counted cycle, stay in STROBE one more cycle and re-sample each cycle. There is no timeout.
  - Read data: rdata <= mem_din on the clock edge that leaves STROBE.
- HOLD: strobes deasserted; ce_n, address, be_n and (on writes) data/doe remain driven.
  - In the last HOLD cycle, assert ack of the granted port for exactly one cycle. Then go to IDLE.
  - In the IDLE cycle mem_ce_n = 1 and mem_doe = 0.
- Timing:
  - Latency from a request seen in IDLE to ack, with no wait: 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles. Ack is in the last of those cycles.
  - Default parameters give ack in cycle 5, counting the grant cycle as 1.
  - Bus turnaround: at least one IDLE cycle (ce_n high) between accesses.
- Handshake rules:
  - A requester may drop req the cycle after ack.
  - req still high in the IDLE cycle after ack is a new access.
  - Inputs that change while req is pending and not yet granted are allowed; values are captured at grant.
- rdata holds its value until the next read completes. Writes do not alter it.
- A requester's req dropping after grant, before ack, is illegal. The transaction completes and acks regardless.
- Only one port is acked per transaction; ack0 and ack1 are never high together.

Test Plan:
- Write, port 0, addr 0x83000000, data 0xabbabeef, be_n 0000, default parameters -> ce_n low cycles 2-5, we_n low cycles 3-4, doe high cycles 2-5, ack0 in cycle 5, oe_n never low.
- Read back the same address with the device returning 0xabbabeef -> oe_n low cycles 3-4, rdata = 0xabbabeef with ack0, we_n never low.
- Both ports write continuously after reset -> grant order 0,1,0,1. Each ack is followed by one IDLE cycle with ce_n high; no port is starved.
- Read with mem_wait_n held low 3 cycles over the final strobe cycle -> strobe extended by 3 cycles, ack delayed by 3, rdata sampled on the strobe exit edge.
- Port 1 write, be_n 4'b1110, data 0x000000A5 -> mem_be_n = 1110 for the whole transaction, ack1 only.
- rst asserted mid-STROBE of a write -> we_n/ce_n high and doe low immediately, no ack. After release, a reissued request completes normally.
